// File: rtl/nibbler_pkg.sv
// nibbler_pkg: shared fetch defaults, two-byte opcode mask and fetch-state encoding
package nibbler_pkg;
  localparam int ADDR_W_DEF = 12;
  localparam int DATA_W_DEF = 8;
  localparam logic [11:0] RESET_PC_DEF = 12'h000;
  localparam logic [15:0] LONG_MASK = 16'h030B;
  typedef enum logic [1:0] {FETCH1, FETCH2, PRESENT} fetch_state_e;
endpackage

// File: rtl/pc_reg.sv
// pc_reg: fetch address register (load > increment > hold); ports clk, reset, inc_i, load_i, load_addr_i, pc_o
module pc_reg
  import nibbler_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(RESET_PC_DEF)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              inc_i,
  input  logic              load_i,
  input  logic [ADDR_W-1:0] load_addr_i,
  output logic [ADDR_W-1:0] pc_o
);
  logic [ADDR_W-1:0] pc_q, pc_d;
  always_comb pc_d = load_i ? load_addr_i : inc_i ? pc_q + ADDR_W'(1) : pc_q;
  always_ff @(posedge clk or posedge reset)
    if (reset) pc_q <= RESET_PC;
    else pc_q <= pc_d;
  assign pc_o = pc_q;
endmodule

// File: rtl/rom_fetch_ctrl.sv
// rom_fetch_ctrl: fetches 1/2-byte instructions from program ROM and presents them to the decoder; ports clk, reset, rom_addr/rom_data, stall, instr/operand/instr_valid/instr_ack, jmp_req/jmp_addr, pc
module rom_fetch_ctrl
  import nibbler_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(RESET_PC_DEF)
) (
  input  logic              clk,
  input  logic              reset,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [DATA_W-1:0] rom_data,
  input  logic              stall,
  output logic [DATA_W-1:0] instr,
  output logic [DATA_W-1:0] operand,
  output logic              instr_valid,
  input  logic              instr_ack,
  input  logic              jmp_req,
  input  logic [ADDR_W-1:0] jmp_addr,
  output logic [ADDR_W-1:0] pc
);
  fetch_state_e state_q, state_d;
  logic [DATA_W-1:0] instr_q, instr_d, operand_q, operand_d;
  logic inc, load;
  always_comb begin
    state_d = state_q;
    instr_d = instr_q;
    operand_d = operand_q;
    inc = 1'b0;
    load = 1'b0;
    if (!stall) begin
      case (state_q)
        FETCH1: begin
          instr_d = rom_data;
          inc = 1'b1;
          state_d = LONG_MASK[rom_data[7:4]] ? FETCH2 : PRESENT;
          operand_d = LONG_MASK[rom_data[7:4]] ? operand_q : '0;
        end
        FETCH2: begin
          operand_d = rom_data;
          inc = 1'b1;
          state_d = PRESENT;
        end
        PRESENT: begin
          state_d = instr_ack ? FETCH1 : PRESENT;
          load = instr_ack && jmp_req;
        end
        default: state_d = FETCH1;
      endcase
    end
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state_q <= FETCH1;
      instr_q <= '0;
      operand_q <= '0;
    end else begin
      state_q <= state_d;
      instr_q <= instr_d;
      operand_q <= operand_d;
    end
  pc_reg #(.ADDR_W(ADDR_W), .RESET_PC(RESET_PC)) u_pc (
    .clk(clk),
    .reset(reset),
    .inc_i(inc),
    .load_i(load),
    .load_addr_i(jmp_addr),
    .pc_o(pc)
  );
  assign rom_addr = pc;
  assign instr = instr_q;
  assign operand = operand_q;
  assign instr_valid = state_q == PRESENT;
endmodule

// File: tb/tb_rom_fetch_ctrl.sv
// tb_rom_fetch_ctrl: directed-vector self-checking bench for rom_fetch_ctrl
module tb_rom_fetch_ctrl;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [11:0] rom_addr, pc, jmp_addr;
  logic [7:0] rom_data, instr, operand;
  logic stall = 1'b0, instr_ack = 1'b0, jmp_req = 1'b0, instr_valid;
  logic [7:0] rom [4096];
  int chk_cnt = 0;
  int pass_cnt = 0;
  always #5 clk = ~clk;
  assign rom_data = rom[rom_addr];
  rom_fetch_ctrl dut (
    .clk(clk),
    .reset(reset),
    .rom_addr(rom_addr),
    .rom_data(rom_data),
    .stall(stall),
    .instr(instr),
    .operand(operand),
    .instr_valid(instr_valid),
    .instr_ack(instr_ack),
    .jmp_req(jmp_req),
    .jmp_addr(jmp_addr),
    .pc(pc)
  );
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    chk_cnt++;
    if (obs === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  initial begin
    jmp_addr = 12'h000;
    for (int i = 0; i < 4096; i++) rom[i] = 8'h20;
    rom[12'h000] = 8'h21;
    rom[12'h001] = 8'h15;
    rom[12'h002] = 8'hA7;
    rom[12'h003] = 8'h08;
    rom[12'h3C0] = 8'h4E;
    rom[12'hFFF] = 8'h01;
    #2;
    check("rst_valid", 32'(instr_valid), 0);
    check("rst_pc", 32'(pc), 32'h000);
    check("rst_addr", 32'(rom_addr), 32'h000);
    check("rst_instr", 32'(instr), 0);
    check("rst_operand", 32'(operand), 0);
    @(negedge clk) reset = 1'b0;
    tick();
    check("short_valid", 32'(instr_valid), 1);
    check("short_instr", 32'(instr), 32'h21);
    check("short_operand", 32'(operand), 32'h00);
    check("short_pc", 32'(pc), 32'h001);
    tick();
    check("hold_valid", 32'(instr_valid), 1);
    check("hold_instr", 32'(instr), 32'h21);
    instr_ack = 1'b1;
    tick();
    instr_ack = 1'b0;
    check("accept_valid", 32'(instr_valid), 0);
    tick();
    check("f2_valid", 32'(instr_valid), 0);
    check("f2_pc", 32'(pc), 32'h002);
    tick();
    check("long_valid", 32'(instr_valid), 1);
    check("long_instr", 32'(instr), 32'h15);
    check("long_operand", 32'(operand), 32'hA7);
    check("long_pc", 32'(pc), 32'h003);
    jmp_req = 1'b1;
    jmp_addr = 12'h3C0;
    tick();
    check("jmp_noack_pc", 32'(pc), 32'h003);
    check("jmp_noack_valid", 32'(instr_valid), 1);
    instr_ack = 1'b1;
    tick();
    instr_ack = 1'b0;
    jmp_req = 1'b0;
    check("jmp_addr", 32'(rom_addr), 32'h3C0);
    check("jmp_valid", 32'(instr_valid), 0);
    tick();
    check("jmp_instr", 32'(instr), 32'h4E);
    check("jmp_operand", 32'(operand), 32'h00);
    check("jmp_pc", 32'(pc), 32'h3C1);
    rom[12'h000] = 8'h55;
    instr_ack = 1'b1;
    jmp_req = 1'b1;
    jmp_addr = 12'hFFF;
    tick();
    instr_ack = 1'b0;
    jmp_req = 1'b0;
    check("wrap_start_pc", 32'(pc), 32'hFFF);
    tick();
    check("wrap_mid_pc", 32'(pc), 32'h000);
    tick();
    check("wrap_instr", 32'(instr), 32'h01);
    check("wrap_operand", 32'(operand), 32'h55);
    check("wrap_pc", 32'(pc), 32'h001);
    instr_ack = 1'b1;
    tick();
    tick();
    check("stall_pre_pc", 32'(pc), 32'h002);
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("stall_pc", 32'(pc), 32'h002);
      check("stall_operand", 32'(operand), 32'h55);
      check("stall_valid", 32'(instr_valid), 0);
    end
    stall = 1'b0;
    tick();
    check("resume_operand", 32'(operand), 32'hA7);
    check("resume_instr", 32'(instr), 32'h15);
    check("resume_pc", 32'(pc), 32'h003);
    check("resume_valid", 32'(instr_valid), 1);
    stall = 1'b1;
    jmp_req = 1'b1;
    jmp_addr = 12'h3C0;
    tick();
    check("stall_ack_valid", 32'(instr_valid), 1);
    check("stall_ack_pc", 32'(pc), 32'h003);
    stall = 1'b0;
    jmp_req = 1'b0;
    tick();
    check("release_valid", 32'(instr_valid), 0);
    check("release_pc", 32'(pc), 32'h003);
    tick();
    check("prerst_pc", 32'(pc), 32'h004);
    check("prerst_valid", 32'(instr_valid), 0);
    #2 reset = 1'b1;
    #1;
    check("midrst_valid", 32'(instr_valid), 0);
    check("midrst_pc", 32'(pc), 32'h000);
    check("midrst_instr", 32'(instr), 0);
    check("midrst_operand", 32'(operand), 0);
    @(negedge clk) reset = 1'b0;
    tick();
    check("postrst_instr", 32'(instr), 32'h55);
    check("postrst_operand", 32'(operand), 0);
    check("postrst_valid", 32'(instr_valid), 1);
    check("postrst_pc", 32'(pc), 32'h001);
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end
endmodule

// File: doc/rom_fetch_ctrl.md
ROM_FETCH_CTRL -- requirements
Module: rom_fetch_ctrl

Interface
REQ-001 SHALL have parameter ADDR_W, default 12, meaning program ROM address width.
REQ-002 SHALL have parameter DATA_W, default 8, meaning program ROM word width.
REQ-003 SHALL have parameter RESET_PC, default 12'h000, meaning fetch address after reset.
REQ-004 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-005 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-006 SHALL have port rom_addr  output  ADDR_W  address to program ROM; combinational copy of pc.
REQ-007 SHALL have port rom_data  input  DATA_W  ROM read data, combinational (valid same cycle as rom_addr).
REQ-008 SHALL have port stall  input  1  freezes all state while high.
REQ-009 SHALL have port instr  output  DATA_W  opcode byte of presented instruction.
REQ-010 SHALL have port operand  output  DATA_W  second byte of long instruction; 8'h00 for short.
REQ-011 SHALL have port instr_valid  output  1  instr/operand presented to decoder.
REQ-012 SHALL have port instr_ack  input  1  decoder consumes presented instruction.
REQ-013 SHALL have port jmp_req  input  1  redirect fetch; honoured only with accepted ack.
REQ-014 SHALL have port jmp_addr  input  ADDR_W  redirect target.
REQ-015 SHALL have port pc  output  ADDR_W  current fetch address.

Function
REQ-016 SHALL implement FSM states FETCH1, FETCH2, PRESENT.
REQ-017 FETCH1: SHALL latch rom_data into instr, increment pc; go to FETCH2 if LONG_MASK[rom_data[7:4]] = 1, else clear operand and go to PRESENT.
REQ-018 FETCH2: SHALL latch rom_data into operand, increment pc, go to PRESENT.
REQ-019 PRESENT: SHALL assert instr_valid; instr/operand SHALL hold stable until accepted.
REQ-020 Acceptance SHALL be instr_ack = 1 in PRESENT with stall = 0; next state FETCH1, instr_valid low next cycle.
REQ-021 On acceptance with jmp_req = 1, pc SHALL load jmp_addr (no increment); next FETCH1 fetches jmp_addr.
REQ-022 jmp_req without acceptance SHALL be ignored.
REQ-023 instr_valid SHALL be asserted only in PRESENT.
REQ-024 Latency: short instruction valid 1 cycle after FETCH1; long valid 2 cycles after FETCH1; steady-state throughput 1 short instr / 2 cycles, 1 long / 3 cycles.
REQ-025 pc increment SHALL be modulo 2^ADDR_W (12'hFFF + 1 = 12'h000), including mid long instruction.
REQ-026 stall = 1 SHALL hold state, pc, instr, operand, instr_valid; stall dominates simultaneous instr_ack and jmp_req.
REQ-027 LONG_MASK SHALL be 16'h030B (opcodes 0,1,3,8,9 two-byte; all others one-byte).

Reset
REQ-028 reset assertion SHALL asynchronously force: state FETCH1, pc = rom_addr = RESET_PC, instr = 8'h00, operand = 8'h00, instr_valid = 0.
REQ-029 reset mid-operation (any state) SHALL discard partial instruction; first fetch after release SHALL be RESET_PC.

Structure
REQ-030 Shared package nibbler_pkg SHALL hold ADDR_W/DATA_W defaults, RESET_PC, LONG_MASK, fetch-state enumeration.
REQ-031 pc register with increment/load/hold SHALL be sub-module pc_reg; all else in rom_fetch_ctrl.

Verification
REQ-032 ROM[0]=8'h21 (CMPI), ack held 1 -> instr_valid cycle 2 after reset release, instr=8'h21, operand=8'h00, pc=12'h001.
REQ-033 ROM[0]=8'h15, ROM[1]=8'hA7 -> instr=8'h15, operand=8'hA7, valid after FETCH2, pc=12'h002.
REQ-034 In PRESENT, ack=1, jmp_req=1, jmp_addr=12'h3C0 -> next rom_addr=12'h3C0, instr=ROM[12'h3C0].
REQ-035 pc=12'hFFF, ROM[FFF]=8'h01, ROM[000]=8'h55 -> operand=8'h55, pc=12'h001 (wrap).
REQ-036 stall=1 for 3 cycles during FETCH2 with ack=1 -> pc/operand/state unchanged; resume completes normally.
REQ-037 reset pulse during FETCH2, ack held -> instr_valid=0 immediately; next instr=ROM[RESET_PC].
